sys_reset_sequencer: RTL and testbench

Parametrised system clock/reset controller driving the processor system's reset tree. It takes the board-level `reset` and produces `NUM_CH` staged, synchronously released reset outputs (interconnect, memories, CPU core, peripherals, in index order). It also supports a software-triggered soft reset, per-channel release holds, and a divided clock-enable tick for slow peripherals. It sits between the top-level wrapper's `sys_clock`/`reset` pins and every reset consumer in the design.

---
 rtl/sys_reset_pkg.sv | 20 ++
 rtl/sys_reset_sync.sv | 22 ++
 rtl/sys_reset_sequencer.sv | 137 +++++++++++++
 tb/tb_sys_reset_sequencer.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/sys_reset_pkg.sv
// Shared types and width helpers for the staged reset sequencer.
package sys_reset_pkg;

    typedef enum logic [1:0] {
        SYNC    = 2'd0,
        STRETCH = 2'd1,
        GAP     = 2'd2,
        RUN     = 2'd3
    } rstseq_state_t;

    // Width of a down/up counter holding values 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sys_reset_sync.sv
// Reset-deassert synchronizer: asserts asynchronously, releases after STAGES clean edges.
module reset_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic rst_s_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], 1'b0};
        end
    end

    assign rst_s_o = sync_q[STAGES-1];

endmodule

// File: rtl/sys_reset_sequencer.sv
// Staged reset-tree controller: synchronized release, stretch, per-channel gapped release,
// soft-reset re-sequencing and a divided tick once the whole tree is out of reset.
module sys_reset_sequencer
    import sys_reset_pkg::*;
#(
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned STRETCH_CYCLES = 16,
    parameter int unsigned STAGE_GAP      = 4,
    parameter int unsigned TICK_DIV       = 100
) (
    input  logic                         sys_clock,
    input  logic                         reset,
    input  logic                         soft_reset_req,
    input  logic [NUM_CH-1:0]            ch_hold,
    output logic [NUM_CH-1:0]            ch_reset,
    output logic [$clog2(NUM_CH+1)-1:0]  released_cnt,
    output logic                         all_released,
    output logic                         tick
);

    localparam int unsigned CW = max_u(cnt_width(STRETCH_CYCLES), cnt_width(STAGE_GAP));
    localparam int unsigned TW = cnt_width(TICK_DIV);
    localparam int unsigned RW = $clog2(NUM_CH + 1);

    localparam logic [CW-1:0] STRETCH_LOAD = CW'(STRETCH_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD     = CW'(STAGE_GAP - 1);
    localparam logic [TW-1:0] TICK_LAST    = TW'(TICK_DIV - 1);
    localparam logic [RW-1:0] LAST_IDX     = RW'(NUM_CH - 1);

    rstseq_state_t     state_q;
    logic [CW-1:0]     cnt_q;
    logic [NUM_CH-1:0] ch_reset_q;
    logic [RW-1:0]     rel_cnt_q;
    logic              all_rel_q;
    logic [TW-1:0]     tcnt_q, tcnt_d;
    logic              tick_q, tick_d;

    logic              rst_s;
    logic [NUM_CH-1:0] next_oh;
    logic              next_held;
    logic              last_ch;
    logic              soft_take;

    reset_sync #(
        .STAGES (SYNC_STAGES)
    ) u_reset_sync (
        .clk_i   (sys_clock),
        .rst_i   (reset),
        .rst_s_o (rst_s)
    );

    // The released count doubles as the index of the next channel to release.
    always_comb begin
        next_oh = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (RW'(i) == rel_cnt_q) begin
                next_oh[i] = 1'b1;
            end
        end
    end

    assign next_held = |(ch_hold & next_oh);
    assign last_ch   = (rel_cnt_q == LAST_IDX);
    assign soft_take = soft_reset_req && (state_q != SYNC);

    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            state_q    <= SYNC;
            cnt_q      <= '0;
            ch_reset_q <= '1;
            rel_cnt_q  <= '0;
            all_rel_q  <= 1'b0;
        end else if (soft_take) begin
            state_q    <= STRETCH;
            cnt_q      <= STRETCH_LOAD;
            ch_reset_q <= '1;
            rel_cnt_q  <= '0;
            all_rel_q  <= 1'b0;
        end else begin
            unique case (state_q)
                SYNC: begin
                    if (!rst_s) begin
                        state_q <= STRETCH;
                        cnt_q   <= STRETCH_LOAD;
                    end
                end
                STRETCH, GAP: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else if (!next_held) begin
                        ch_reset_q <= ch_reset_q & ~next_oh;
                        rel_cnt_q  <= rel_cnt_q + RW'(1);
                        if (last_ch) begin
                            state_q   <= RUN;
                            all_rel_q <= 1'b1;
                        end else begin
                            state_q <= GAP;
                            cnt_q   <= GAP_LOAD;
                        end
                    end
                end
                RUN: begin
                end
            endcase
        end
    end

    // Tick runs only while the whole tree is out of reset; a soft reset zeroes it on its own edge.
    always_comb begin
        tcnt_d = '0;
        tick_d = 1'b0;
        if (all_rel_q && !soft_take) begin
            if (tcnt_q == TICK_LAST) begin
                tick_d = 1'b1;
            end else begin
                tcnt_d = tcnt_q + TW'(1);
            end
        end
    end

    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            tcnt_q <= '0;
            tick_q <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            tick_q <= tick_d;
        end
    end

    assign ch_reset     = ch_reset_q;
    assign released_cnt = rel_cnt_q;
    assign all_released = all_rel_q;
    assign tick         = tick_q;

endmodule

// File: tb/tb_sys_reset_sequencer.sv
// Checkpoint-table bench for sys_reset_sequencer with NUM_CH=3, SYNC=2, STRETCH=16, GAP=4, TICK_DIV=8.
module tb_sys_reset_sequencer;

    logic       sys_clock;
    logic       reset;
    logic       soft_reset_req;
    logic [2:0] ch_hold;
    logic [2:0] ch_reset;
    logic [1:0] released_cnt;
    logic       all_released;
    logic       tick;

    sys_reset_sequencer #(
        .NUM_CH         (3),
        .SYNC_STAGES    (2),
        .STRETCH_CYCLES (16),
        .STAGE_GAP      (4),
        .TICK_DIV       (8)
    ) dut (
        .sys_clock      (sys_clock),
        .reset          (reset),
        .soft_reset_req (soft_reset_req),
        .ch_hold        (ch_hold),
        .ch_reset       (ch_reset),
        .released_cnt   (released_cnt),
        .all_released   (all_released),
        .tick           (tick)
    );

    initial begin
        sys_clock = 1'b0;
        forever #5 sys_clock = ~sys_clock;
    end

    typedef struct {
        int         scen;
        int         e;
        logic [2:0] rst;
        logic [1:0] cnt;
        logic       allr;
    } chk_t;

    chk_t vec[$];
    chk_t sb[$];
    int   n_cmp;
    int   n_bad;

    task automatic cmp(input string nm, input int e, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s edge %0d: got %0h expected %0h", nm, e, act, exp);
        end
    endtask

    task automatic add(input int scen, input int e, input logic [2:0] r, input logic [1:0] c, input logic a);
        chk_t t;
        t.scen = scen; t.e = e; t.rst = r; t.cnt = c; t.allr = a;
        vec.push_back(t);
    endtask

    task automatic power_up();
        reset          = 1'b1;
        soft_reset_req = 1'b0;
        ch_hold        = 3'b000;
        repeat (5) @(posedge sys_clock);
        #1;
        cmp("rst_ch_reset", 0, 32'(ch_reset), 32'h7);
        cmp("rst_cnt", 0, 32'(released_cnt), 32'h0);
        cmp("rst_all", 0, 32'(all_released), 32'h0);
        cmp("rst_tick", 0, 32'(tick), 32'h0);
        #1 reset = 1'b0;
    endtask

    // Drives one scenario edge by edge; edge 1 is the first posedge after this call.
    task automatic run_edges(input int scen, input int last_e, input int hold_until,
                             input int soft_e, input int t0, input int t1, input int t2);
        chk_t c;
        sb.delete();
        foreach (vec[i]) if (vec[i].scen == scen) sb.push_back(vec[i]);
        for (int e = 1; e <= last_e; e++) begin
            ch_hold        = (e <= hold_until) ? 3'b010 : 3'b000;
            soft_reset_req = (e == soft_e);
            @(posedge sys_clock);
            #1;
            while (sb.size() > 0 && sb[0].e == e) begin
                c = sb.pop_front();
                cmp($sformatf("s%0d_ch_reset", scen), e, 32'(ch_reset), 32'(c.rst));
                cmp($sformatf("s%0d_released_cnt", scen), e, 32'(released_cnt), 32'(c.cnt));
                cmp($sformatf("s%0d_all_released", scen), e, 32'(all_released), 32'(c.allr));
            end
            cmp($sformatf("s%0d_tick", scen), e, 32'(tick), 32'(e == t0 || e == t1 || e == t2));
        end
        ch_hold        = 3'b000;
        soft_reset_req = 1'b0;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL s%0d_unvisited: %0d checkpoints left, required 0", scen, sb.size());
        end
    endtask

    initial begin
        n_cmp          = 0;
        n_bad          = 0;
        reset          = 1'b1;
        soft_reset_req = 1'b0;
        ch_hold        = 3'b000;

        // 1: power-up release at 19/23/27
        add(1, 18, 3'b111, 2'd0, 1'b0);
        add(1, 19, 3'b110, 2'd1, 1'b0);
        add(1, 22, 3'b110, 2'd1, 1'b0);
        add(1, 23, 3'b100, 2'd2, 1'b0);
        add(1, 26, 3'b100, 2'd2, 1'b0);
        add(1, 27, 3'b000, 2'd3, 1'b1);
        add(1, 34, 3'b000, 2'd3, 1'b1);
        // 2: ch1 held through edge 40
        add(2, 19, 3'b110, 2'd1, 1'b0);
        add(2, 40, 3'b110, 2'd1, 1'b0);
        add(2, 41, 3'b100, 2'd2, 1'b0);
        add(2, 44, 3'b100, 2'd2, 1'b0);
        add(2, 45, 3'b000, 2'd3, 1'b1);
        // 3: soft reset in RUN at edge 50
        add(3, 27, 3'b000, 2'd3, 1'b1);
        add(3, 49, 3'b000, 2'd3, 1'b1);
        add(3, 50, 3'b111, 2'd0, 1'b0);
        add(3, 65, 3'b111, 2'd0, 1'b0);
        add(3, 66, 3'b110, 2'd1, 1'b0);
        add(3, 69, 3'b110, 2'd1, 1'b0);
        add(3, 70, 3'b100, 2'd2, 1'b0);
        add(3, 74, 3'b000, 2'd3, 1'b1);
        // 4: lead-in to the async pulse, then the restarted sequence (soft request in SYNC ignored)
        add(4, 19, 3'b110, 2'd1, 1'b0);
        add(4, 21, 3'b110, 2'd1, 1'b0);
        add(5, 18, 3'b111, 2'd0, 1'b0);
        add(5, 19, 3'b110, 2'd1, 1'b0);
        add(5, 23, 3'b100, 2'd2, 1'b0);
        add(5, 27, 3'b000, 2'd3, 1'b1);
        // 6: soft reset on the ch1 release edge
        add(6, 22, 3'b110, 2'd1, 1'b0);
        add(6, 23, 3'b111, 2'd0, 1'b0);
        add(6, 38, 3'b111, 2'd0, 1'b0);
        add(6, 39, 3'b110, 2'd1, 1'b0);
        add(6, 43, 3'b100, 2'd2, 1'b0);
        add(6, 47, 3'b000, 2'd3, 1'b1);

        power_up();
        run_edges(1, 55, 0, 0, 35, 43, 51);

        power_up();
        run_edges(2, 55, 40, 0, 53, 0, 0);

        power_up();
        run_edges(3, 82, 0, 50, 35, 43, 82);

        power_up();
        run_edges(4, 21, 0, 0, 0, 0, 0);
        #2 reset = 1'b1;
        #1;
        cmp("s4_async_ch_reset", 21, 32'(ch_reset), 32'h7);
        cmp("s4_async_cnt", 21, 32'(released_cnt), 32'h0);
        cmp("s4_async_all", 21, 32'(all_released), 32'h0);
        #2 reset = 1'b0;
        run_edges(5, 30, 0, 2, 0, 0, 0);

        power_up();
        run_edges(6, 50, 0, 23, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
